vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  640x480@60Hz VGA timing generator and output stage for the snake display path.
//  Free-running column/row counters supply pixel_row, pixel_column and vert_sync to the game logic.
//  Game colour bits return through a delay-matched output stage that drives the DAC/connector pins.
//  Sync and blanking are delayed by RGB_LAT so they stay aligned with the game's RAM read latency.
// PARAMETERS
//  RGB_LAT   1   pixel_clock cycles from pixel_row/pixel_column to valid red_in/green_in/blue_in; legal 0..4
//  H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48   horizontal timing in pixels (line = 800)
//  V_VIS 480, V_FP 10, V_SYNC 2,  V_BP 33   vertical timing in lines (frame = 525)
// PORTS
//  pixel_clock   in   1   25.175 MHz pixel clock; all logic on its rising edge
//  reset         in   1   synchronous, active-low
//  red_in        in   1   game red, valid RGB_LAT cycles after the matching coordinate
//  green_in      in   1   game green, same timing as red_in
//  blue_in       in   1   game blue, same timing as red_in
//  pixel_column  out  10  current column, 0..799
//  pixel_row     out  10  current row, 0..524
//  horiz_sync    out  1   undelayed hsync, active-low
//  vert_sync     out  1   undelayed vsync, active-low (high = frame running)
//  video_on      out  1   undelayed visible-area flag
//  vga_red/vga_green/vga_blue  out 1 each  blanked, delayed colour to pins
//  vga_hsync     out  1   horiz_sync delayed RGB_LAT cycles
//  vga_vsync     out  1   vert_sync delayed RGB_LAT cycles
// BEHAVIOUR
//  Reset (reset==0 at a clock edge): pixel_column=0, pixel_row=0, horiz_sync=1, vert_sync=1,
//   video_on=0; every delay stage cleared to hsync=1, vsync=1, video=0; vga_* colour=0.
//   Reset mid-frame takes effect at the next edge, with no frame completion.
//  Counters: column +1 per clock; at 799 it wraps to 0 and row +1; at (799,524) both wrap to 0.
//  Decodes are registered and aligned with the counter values they describe:
//   horiz_sync=0 iff 656<=column<=751; vert_sync=0 iff 490<=row<=491;
//   video_on=1 iff column<640 && row<480.
//   The first pixel after reset release (0,0) reads video_on=0. This is accepted.
//  Delay line: RGB_LAT-deep shift registers carry {horiz_sync,vert_sync,video_on}.
//   vga_red = red_in & video_on_d, same for green and blue; colour is forced to 0 outside the visible area.
//   With RGB_LAT=0 the stage is combinational pass-through with no added register.
//  Rows 480..489 (front porch) are blanked on the pins. Game logic may use them for RAM writes.
//  Widths: counters are 10-bit unsigned; no arithmetic on coordinates beyond the increment.
//  Total latency from counter edge to pin: RGB_LAT cycles for sync and colour alike.
// CONFIGURATION
//  VGA_FRAME_CNT_EN defined: adds ports frame_count out 16 and frame_start out 1.
//   frame_start is high for exactly the one cycle in which the counters show (0,0); it is 0 in reset.
//   frame_count increments by 1 at each (799,524)->(0,0) wrap, wraps 65535->0, and resets to 0.
//  VGA_FRAME_CNT_EN undefined: both ports and their logic are absent; all other behaviour is identical.
// TESTING
//  1 Hold reset low 10 clocks -> column=row=0, horiz_sync=vert_sync=vga_hsync=vga_vsync=1, vga_* colour=0.
//  2 Release reset, run 800 clocks -> horiz_sync low exactly 96 cycles (cols 656-751); column 799->0 with row 0->1.
//  3 Run 420000 clocks -> vert_sync low exactly 1600 cycles (rows 490-491); frame period 420000 clocks.
//  4 RGB_LAT=1, red_in=1 constant -> vga_red high 640 clocks per line, rising 1 clock after column 0;
//    low through rows 480-524; vga_hsync lags horiz_sync by 1 clock.
//  5 Assert reset at row 300, col 400 -> next edge gives counters 0 and all outputs at reset values;
//    no stale delay-line bit reaches vga_*.
//  6 VGA_FRAME_CNT_EN defined, run 3 frames -> frame_count=3; frame_start pulses once per 420000 clocks, 1 cycle wide.

Source files
------------

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : 640x480@60Hz VGA timing generator with latency-matched colour/sync
//            output stage. Optional frame counter ports under VGA_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_sync_gen #(
    parameter int RGB_LAT = 1,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       red_in,
    input  logic       green_in,
    input  logic       blue_in,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0] frame_count,
    output logic        frame_start,
`endif
    output logic       vga_red,
    output logic       vga_green,
    output logic       vga_blue,
    output logic       vga_hsync,
    output logic       vga_vsync
);

    localparam logic [9:0] H_LAST       = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
    localparam logic [9:0] V_LAST       = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VIS);

    logic [9:0] column_next;
    logic [9:0] row_next;
    logic       line_end;
    logic       frame_end;

    always_comb begin
        line_end    = (pixel_column == H_LAST);
        frame_end   = line_end && (pixel_row == V_LAST);
        column_next = line_end ? 10'd0 : pixel_column + 10'd1;
        row_next    = pixel_row;
        if (frame_end)
            row_next = 10'd0;
        else if (line_end)
            row_next = pixel_row + 10'd1;
    end

    // Decodes are taken from the next counter value so they line up with it.
    always_ff @(posedge pixel_clock) begin
        if (!reset) begin
            pixel_column <= 10'd0;
            pixel_row    <= 10'd0;
            horiz_sync   <= 1'b1;
            vert_sync    <= 1'b1;
            video_on     <= 1'b0;
        end else begin
            pixel_column <= column_next;
            pixel_row    <= row_next;
            horiz_sync   <= !((column_next >= H_SYNC_FIRST) && (column_next <= H_SYNC_LAST));
            vert_sync    <= !((row_next >= V_SYNC_FIRST) && (row_next <= V_SYNC_LAST));
            video_on     <= (column_next < H_VIS_END) && (row_next < V_VIS_END);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge pixel_clock) begin
        if (!reset) begin
            frame_count <= 16'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (column_next == 10'd0) && (row_next == 10'd0);
            if (frame_end)
                frame_count <= frame_count + 16'd1;
        end
    end
`endif

    logic hsync_d;
    logic vsync_d;
    logic video_d;

    generate
        if (RGB_LAT == 0) begin : g_passthru
            assign hsync_d = horiz_sync;
            assign vsync_d = vert_sync;
            assign video_d = video_on;
        end else begin : g_delay
            logic [2:0] pipe [RGB_LAT];

            always_ff @(posedge pixel_clock) begin
                if (!reset) begin
                    for (int i = 0; i < RGB_LAT; i++)
                        pipe[i] <= 3'b110;
                end else begin
                    pipe[0] <= {horiz_sync, vert_sync, video_on};
                    for (int i = 1; i < RGB_LAT; i++)
                        pipe[i] <= pipe[i-1];
                end
            end

            assign {hsync_d, vsync_d, video_d} = pipe[RGB_LAT-1];
        end
    endgenerate

    // Colour arrives already RGB_LAT late, so only the blanking gate is applied here.
    assign vga_red   = red_in   & video_d;
    assign vga_green = green_in & video_d;
    assign vga_blue  = blue_in  & video_d;
    assign vga_hsync = hsync_d;
    assign vga_vsync = vsync_d;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Randomized self-checking bench for vga_sync_gen (full 640x480
//            geometry plus a shrunken geometry that reaches every frame boundary).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_sync_gen;

    localparam int LAT   [2] = '{1, 2};
    localparam int HV    [2] = '{640, 40};
    localparam int HF    [2] = '{16, 4};
    localparam int HS    [2] = '{96, 8};
    localparam int HB    [2] = '{48, 4};
    localparam int VV    [2] = '{480, 30};
    localparam int VF    [2] = '{10, 3};
    localparam int VS    [2] = '{2, 2};
    localparam int VB    [2] = '{33, 5};
    localparam int NCYC  = 52000;
    localparam int RST_POS = 30 * 800 + 400;

    logic pixel_clock = 1'b0;
    logic reset = 1'b0;
    logic red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;

    logic [9:0] col_a, row_a, col_b, row_b;
    logic hs_a, vs_a, von_a, r_a, g_a, b_a, vh_a, vv_a;
    logic hs_b, vs_b, von_b, r_b, g_b, b_b, vh_b, vv_b;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
    logic fs_a, fs_b;
`endif

    always #20 pixel_clock = ~pixel_clock;

    vga_sync_gen #(.RGB_LAT(LAT[0]), .H_VIS(HV[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
                   .V_VIS(VV[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0])) dut (
        .pixel_clock(pixel_clock), .reset(reset),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pixel_column(col_a), .pixel_row(row_a),
        .horiz_sync(hs_a), .vert_sync(vs_a), .video_on(von_a),
`ifdef VGA_FRAME_CNT_EN
        .frame_count(fc_a), .frame_start(fs_a),
`endif
        .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
        .vga_hsync(vh_a), .vga_vsync(vv_a)
    );

    vga_sync_gen #(.RGB_LAT(LAT[1]), .H_VIS(HV[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
                   .V_VIS(VV[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1])) dut_small (
        .pixel_clock(pixel_clock), .reset(reset),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pixel_column(col_b), .pixel_row(row_b),
        .horiz_sync(hs_b), .vert_sync(vs_b), .video_on(von_b),
`ifdef VGA_FRAME_CNT_EN
        .frame_count(fc_b), .frame_start(fs_b),
`endif
        .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
        .vga_hsync(vh_b), .vga_vsync(vv_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: position within the frame as a single cycle index.
    int         pos   [2];
    bit         fresh [2];
    logic [2:0] cur   [2];
    logic [2:0] hist  [2][5];
    int         fcnt  [2];

    function automatic int line_len(input int k);
        return HV[k] + HF[k] + HS[k] + HB[k];
    endfunction

    function automatic int frame_len(input int k);
        return line_len(k) * (VV[k] + VF[k] + VS[k] + VB[k]);
    endfunction

    function automatic logic [2:0] decode(input int k, input int p);
        int c, r;
        logic h, v, vid;
        c   = p % line_len(k);
        r   = p / line_len(k);
        h   = !(c >= HV[k] + HF[k] && c < HV[k] + HF[k] + HS[k]);
        v   = !(r >= VV[k] + VF[k] && r < VV[k] + VF[k] + VS[k]);
        vid = (c < HV[k]) && (r < VV[k]);
        return {h, v, vid};
    endfunction

    task automatic model_edge(input bit in_reset);
        for (int k = 0; k < 2; k++) begin
            if (in_reset) begin
                pos[k]   = 0;
                fresh[k] = 1'b1;
                cur[k]   = 3'b110;
                fcnt[k]  = 0;
                for (int i = 0; i < 5; i++) hist[k][i] = 3'b110;
            end else begin
                for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = cur[k];
                if (pos[k] == frame_len(k) - 1) fcnt[k] = (fcnt[k] + 1) % 65536;
                pos[k]   = (pos[k] + 1) % frame_len(k);
                fresh[k] = 1'b0;
                cur[k]   = decode(k, pos[k]);
            end
        end
    endtask

    task automatic check_inst(input int k, input string nm,
                              input logic [9:0] col, input logic [9:0] row,
                              input logic hs, input logic vs, input logic von,
                              input logic r, input logic g, input logic b,
                              input logic vh, input logic vv);
        logic [2:0] dly;
        dly = (LAT[k] == 0) ? cur[k] : hist[k][LAT[k]-1];
        check_val({nm, "_column"},   32'(col), 32'(pos[k] % line_len(k)));
        check_val({nm, "_row"},      32'(row), 32'(pos[k] / line_len(k)));
        check_val({nm, "_hsync"},    32'(hs),  32'(cur[k][2]));
        check_val({nm, "_vsync"},    32'(vs),  32'(cur[k][1]));
        check_val({nm, "_video_on"}, 32'(von), 32'(cur[k][0]));
        check_val({nm, "_vga_hsync"}, 32'(vh), 32'(dly[2]));
        check_val({nm, "_vga_vsync"}, 32'(vv), 32'(dly[1]));
        check_val({nm, "_vga_red"},   32'(r),  32'(red_in   & dly[0]));
        check_val({nm, "_vga_green"}, 32'(g),  32'(green_in & dly[0]));
        check_val({nm, "_vga_blue"},  32'(b),  32'(blue_in  & dly[0]));
    endtask

    initial begin
        bit rst_edge;
        bit forced = 1'b0;
        int hlen = 0;
        int vlen = 0;
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0; fresh[k] = 1'b1; cur[k] = 3'b110; fcnt[k] = 0;
            for (int i = 0; i < 5; i++) hist[k][i] = 3'b110;
        end

        for (int n = 0; n < NCYC; n++) begin
            @(posedge pixel_clock);
            rst_edge = !reset;
            model_edge(rst_edge);
            #1;
            {red_in, green_in, blue_in} = 3'($urandom);
            if (n < 10)
                reset = 1'b0;
            else if (!forced && pos[0] == RST_POS) begin
                reset  = 1'b0;
                forced = 1'b1;
            end else if (forced && $urandom_range(0, 7999) == 0)
                reset = 1'b0;
            else
                reset = 1'b1;
            #1;
            check_inst(0, "full",  col_a, row_a, hs_a, vs_a, von_a, r_a, g_a, b_a, vh_a, vv_a);
            check_inst(1, "small", col_b, row_b, hs_b, vs_b, von_b, r_b, g_b, b_b, vh_b, vv_b);
`ifdef VGA_FRAME_CNT_EN
            check_val("full_frame_start",  32'(fs_a), 32'(pos[0] == 0 && !fresh[0]));
            check_val("small_frame_start", 32'(fs_b), 32'(pos[1] == 0 && !fresh[1]));
            check_val("full_frame_count",  32'(fc_a), 32'(fcnt[0]));
            check_val("small_frame_count", 32'(fc_b), 32'(fcnt[1]));
`endif
            // Sync pulse widths, measured independently of the per-cycle model.
            if (rst_edge) begin
                hlen = 0;
                vlen = 0;
            end else begin
                if (!hs_a) hlen++;
                else if (hlen != 0) begin
                    check_val("full_hsync_width", 32'(hlen), 32'(HS[0]));
                    hlen = 0;
                end
                if (!vs_b) vlen++;
                else if (vlen != 0) begin
                    check_val("small_vsync_width", 32'(vlen), 32'(VS[1] * line_len(1)));
                    vlen = 0;
                end
            end
        end
        check_val("midframe_reset_seen", 32'(forced), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
